// File: rtl/adc_seq_pkg.sv
// Shared state encoding and measurement-record layout for the ADC sample sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStart,
        StWait,
        StPush,
        StNext
    } seq_state_e;

    localparam int unsigned MEAS_WIDTH   = 56;
    localparam int unsigned TS_LSB       = 24;
    localparam int unsigned TS_WIDTH     = 32;
    localparam int unsigned CH_LSB       = 21;
    localparam int unsigned CH_WIDTH     = 3;
    localparam int unsigned TO_BIT       = 20;
    localparam int unsigned OVR_BIT      = 19;
    localparam int unsigned SAMPLE_WIDTH = 16;

    function automatic logic [MEAS_WIDTH-1:0] pack_record(
        input logic [TS_WIDTH-1:0]     ts,
        input logic [CH_WIDTH-1:0]     ch,
        input logic                    to,
        input logic                    ovr,
        input logic [SAMPLE_WIDTH-1:0] sample
    );
        logic [MEAS_WIDTH-1:0] rec;
        rec                          = '0;
        rec[TS_LSB +: TS_WIDTH]      = ts;
        rec[CH_LSB +: CH_WIDTH]      = ch;
        rec[TO_BIT]                  = to;
        rec[OVR_BIT]                 = ovr;
        rec[SAMPLE_WIDTH-1:0]        = sample;
        return rec;
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// ADC start/done handshake plus FIFO write port; master = sequencer side.
interface adc_sample_sequencer_if #(
    parameter int unsigned ADC_WIDTH = 16
);

    logic                              adc_start_o;
    logic [2:0]                        adc_ch_o;
    logic                              adc_done_i;
    logic [ADC_WIDTH-1:0]              adc_data_i;
    logic                              fifo_wr_en_o;
    logic [adc_seq_pkg::MEAS_WIDTH-1:0] fifo_wdata_o;
    logic                              fifo_full_i;

    modport master (
        output adc_start_o, adc_ch_o, fifo_wr_en_o, fifo_wdata_o,
        input  adc_done_i, adc_data_i, fifo_full_i
    );

    modport slave (
        input  adc_start_o, adc_ch_o, fifo_wr_en_o, fifo_wdata_o,
        output adc_done_i, adc_data_i, fifo_full_i
    );

endinterface

// File: rtl/adc_seq_chan_pick.sv
// Finds the lowest enabled channel, either from bit 0 (first_i) or strictly above cur_i.
module adc_seq_chan_pick #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [2:0]        cur_i,
    input  logic              first_i,
    output logic [2:0]        next_o,
    output logic              valid_o
);

    always_comb begin
        next_o  = '0;
        valid_o = 1'b0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                next_o  = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Steps through enabled ADC channels on trigger/periodic tick and pushes 56-bit records.
// Optional: define ADC_SEQ_AVG_EN to average four conversions per channel.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ADC_WIDTH      = 16,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   trig_i,
    input  logic [15:0]            period_i,
    input  logic [NUM_CH-1:0]      ch_mask_i,
    input  logic                   ovr_clr_i,
    adc_sample_sequencer_if.master bus,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int unsigned CNT_MAX =
        (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [2:0]            ch_q, ch_d;
    logic [MEAS_WIDTH-1:0] rec_q, rec_d;
    logic [31:0]           ts_q;
    logic [15:0]           per_cnt_q;
    logic                  overrun_q;
    logic                  tick, start_req, drop;
    logic [NUM_CH-1:0]     pick_mask;
    logic                  pick_first, pick_valid;
    logic [2:0]            pick_next;
`ifdef ADC_SEQ_AVG_EN
    logic [17:0]           acc_q, acc_d, acc_sum;
    logic [1:0]            nconv_q, nconv_d;
`endif

    assign tick      = (period_i != 16'd0) && (per_cnt_q >= period_i - 16'd1);
    assign start_req = trig_i || tick;
    assign drop      = (state_q == StPush) && bus.fifo_full_i;

    // In IDLE the live mask picks the first channel; afterwards the latched mask is walked.
    assign pick_first = (state_q == StIdle);
    assign pick_mask  = pick_first ? ch_mask_i : mask_q;

    adc_seq_chan_pick #(.NUM_CH(NUM_CH)) u_chan_pick (
        .mask_i  (pick_mask),
        .cur_i   (ch_q),
        .first_i (pick_first),
        .next_o  (pick_next),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        rec_d   = rec_q;
`ifdef ADC_SEQ_AVG_EN
        acc_d   = acc_q;
        nconv_d = nconv_q;
        acc_sum = acc_q + 18'(bus.adc_data_i);
`endif
        unique case (state_q)
            StIdle: begin
                if (start_req && (ch_mask_i != '0)) begin
                    mask_d  = ch_mask_i;
                    ch_d    = pick_next;
                    cnt_d   = '0;
                    state_d = StSettle;
`ifdef ADC_SEQ_AVG_EN
                    acc_d   = '0;
                    nconv_d = '0;
`endif
                end
            end
            StSettle: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = StStart;
                else                                     cnt_d   = cnt_q + 1'b1;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.adc_done_i) begin
`ifdef ADC_SEQ_AVG_EN
                    if (nconv_q == 2'd3) begin
                        rec_d   = pack_record(ts_q, ch_q, 1'b0, overrun_q, acc_sum[17:2]);
                        state_d = StPush;
                    end else begin
                        acc_d   = acc_sum;
                        nconv_d = nconv_q + 1'b1;
                        state_d = StStart;
                    end
`else
                    rec_d   = pack_record(ts_q, ch_q, 1'b0, overrun_q, 16'(bus.adc_data_i));
                    state_d = StPush;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rec_d   = pack_record(ts_q, ch_q, 1'b1, overrun_q, '0);
                    state_d = StPush;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPush: state_d = StNext;
            StNext: begin
                if (pick_valid) begin
                    ch_d    = pick_next;
                    cnt_d   = '0;
                    state_d = StSettle;
`ifdef ADC_SEQ_AVG_EN
                    acc_d   = '0;
                    nconv_d = '0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            rec_q     <= '0;
            ts_q      <= '0;
            per_cnt_q <= '0;
            overrun_q <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            acc_q     <= '0;
            nconv_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            rec_q     <= rec_d;
            ts_q      <= ts_q + 32'd1;
            per_cnt_q <= (period_i == 16'd0 || tick) ? 16'd0 : per_cnt_q + 16'd1;
            // A drop in the same cycle as a clear keeps the flag set.
            overrun_q <= drop || (overrun_q && !ovr_clr_i);
`ifdef ADC_SEQ_AVG_EN
            acc_q     <= acc_d;
            nconv_q   <= nconv_d;
`endif
        end
    end

    assign bus.adc_start_o  = (state_q == StStart);
    assign bus.adc_ch_o     = ch_q;
    assign bus.fifo_wr_en_o = (state_q == StPush) && !bus.fifo_full_i;
    assign bus.fifo_wdata_o = rec_q;
    assign busy_o           = (state_q != StIdle);
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized scoreboard bench for adc_sample_sequencer with a behavioural ADC responder.
module tb_adc_sample_sequencer;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 255;

    typedef struct {
        logic [2:0]  ch;
        bit          first;
        logic [31:0] req_ts;
    } exp_start_t;

    logic              PCLK;
    logic              PRESET;
    logic              trig_i;
    logic [15:0]       period_i;
    logic [NUM_CH-1:0] ch_mask_i;
    logic              ovr_clr_i;
    logic              busy_o;
    logic              overrun_o;

    adc_sample_sequencer_if #(.ADC_WIDTH(16)) bus ();

    adc_sample_sequencer #(
        .NUM_CH         (NUM_CH),
        .ADC_WIDTH      (16),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .trig_i    (trig_i),
        .period_i  (period_i),
        .ch_mask_i (ch_mask_i),
        .ovr_clr_i (ovr_clr_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          errors = 0;
    int          checks = 0;
    int          push_cnt = 0;
    logic [31:0] tb_ts;
    logic [55:0] sb_q[$];
    exp_start_t  exp_start_q[$];
    int          delay_sel = 0;   // 0 random, >0 fixed delay, -1 never respond
    bit          data_fixed = 0;
    logic [15:0] data_val = '0;
    bit          suppress = 0;
    bit          model_ovr = 0;

    // Cycle count since the last reset edge: the timestamp the DUT should report.
    always @(posedge PCLK) begin
        if (PRESET) tb_ts <= '0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_record(input logic [31:0] ts, input logic [2:0] ch, input bit to,
                                 input logic [15:0] s);
        if (suppress) return;
        if (bus.fifo_full_i) model_ovr = 1'b1;
        else sb_q.push_back({ts, ch, to, model_ovr, 3'b000, s});
    endtask

    // Monitor: every FIFO push must match the oldest expected record.
    always @(negedge PCLK) begin
        if (!PRESET && bus.fifo_wr_en_o === 1'b1) begin
            push_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got 0x%0h, no record expected", bus.fifo_wdata_o);
            end else begin
                check("record", 64'(bus.fifo_wdata_o), 64'(sb_q.pop_front()));
            end
        end
    end

    // ADC responder: answers each start after a chosen delay and predicts the record.
    initial begin
        exp_start_t  e;
        int          d;
        logic [15:0] dat;
        logic [2:0]  ch;
        bus.adc_done_i = 1'b0;
        bus.adc_data_i = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESET && bus.adc_start_o === 1'b1) begin
                ch = bus.adc_ch_o;
                if (exp_start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got ch %0d, no start expected", ch);
                end else begin
                    e = exp_start_q.pop_front();
                    check("adc_ch", 64'(ch), 64'(e.ch));
                    if (e.first) check("start_latency", 64'(tb_ts - e.req_ts), 64'(SETTLE + 1));
                end
                if (delay_sel < 0) begin
                    repeat (TIMEOUT) @(negedge PCLK);
                    expect_record(tb_ts, ch, 1'b1, 16'h0000);
                end else begin
                    d   = (delay_sel > 0) ? delay_sel : int'($urandom_range(1, 30));
                    dat = data_fixed ? data_val : 16'($urandom);
                    repeat (d) @(negedge PCLK);
                    bus.adc_done_i = 1'b1;
                    bus.adc_data_i = dat;
                    expect_record(tb_ts, ch, 1'b0, dat);
                    @(negedge PCLK);
                    bus.adc_done_i = 1'b0;
                    bus.adc_data_i = 16'($urandom);
                end
            end
        end
    end

    task automatic trigger(input logic [3:0] m);
        exp_start_t e;
        bit         first = 1'b1;
        @(negedge PCLK);
        ch_mask_i = m;
        trig_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.ch     = 3'(i);
                e.first  = first;
                e.req_ts = tb_ts;
                exp_start_q.push_back(e);
                first = 1'b0;
            end
        end
        @(negedge PCLK);
        trig_i    = 1'b0;
        ch_mask_i = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(busy_o == 1'b0 && sb_q.size() == 0 && exp_start_q.size() == 0) && n < 3000);
        check("idle_reached", 64'(n < 3000), 64'd1);
    endtask

    task automatic clear_overrun();
        @(negedge PCLK);
        ovr_clr_i = 1'b1;
        @(negedge PCLK);
        ovr_clr_i = 1'b0;
        model_ovr = 1'b0;
        @(negedge PCLK);
        check("overrun_cleared", 64'(overrun_o), 64'd0);
    endtask

    initial begin
        int          n;
        int          base_cnt;
        logic [31:0] c;
        logic [3:0]  m;
        exp_start_t  e;

        PRESET          = 1'b1;
        trig_i          = 1'b0;
        period_i        = '0;
        ch_mask_i       = '0;
        ovr_clr_i       = 1'b0;
        bus.fifo_full_i = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_start", 64'(bus.adc_start_o), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_wr_en_o), 64'd0);
        check("rst_wdata", 64'(bus.fifo_wdata_o), 64'd0);
        check("rst_overrun", 64'(overrun_o), 64'd0);
        check("rst_adc_ch", 64'(bus.adc_ch_o), 64'd0);

        // Single channel, fixed response; busy must drop two cycles after the push.
        delay_sel  = 10;
        data_fixed = 1'b1;
        data_val   = 16'h1234;
        trigger(4'b0001);
        n = 0;
        while (bus.fifo_wr_en_o !== 1'b1 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("single_push_seen", 64'(n < 100), 64'd1);
        @(negedge PCLK);
        check("busy_in_next", 64'(busy_o), 64'd1);
        @(negedge PCLK);
        check("busy_after_next", 64'(busy_o), 64'd0);
        wait_idle();

        // Two channels in ascending order.
        delay_sel  = 0;
        data_fixed = 1'b0;
        trigger(4'b1010);
        wait_idle();

        // No done at all: timeout record.
        delay_sel = -1;
        trigger(4'b0001);
        wait_idle();
        delay_sel = 0;

        // FIFO full drops the record and sets overrun; the next record carries it.
        bus.fifo_full_i = 1'b1;
        trigger(4'b0001);
        wait_idle();
        check("overrun_set", 64'(overrun_o), 64'd1);
        bus.fifo_full_i = 1'b0;
        trigger(4'b0100);
        wait_idle();
        clear_overrun();

        // Continuous mode, period 100; a trigger while busy must be ignored.
        delay_sel = 5;
        ch_mask_i = 4'b0001;
        base_cnt  = push_cnt;
        @(negedge PCLK);
        period_i = 16'd100;
        c        = tb_ts;
        for (int k = 0; k < 5; k++) begin
            e.ch     = 3'd0;
            e.first  = 1'b1;
            e.req_ts = c + 32'd99 + 32'(100 * k);
            exp_start_q.push_back(e);
        end
        while (tb_ts != c + 32'd101) @(negedge PCLK);
        check("busy_during_tick", 64'(busy_o), 64'd1);
        trig_i = 1'b1;
        @(negedge PCLK);
        trig_i = 1'b0;
        while (tb_ts != c + 32'd529) @(negedge PCLK);
        period_i = 16'd0;
        wait_idle();
        check("periodic_push_count", 64'(push_cnt - base_cnt), 64'd5);
        delay_sel = 0;

        // Randomized sequences with occasional full FIFO and overrun clears.
        for (int t = 0; t < 40; t++) begin
            m = 4'($urandom_range(0, 15));
            bus.fifo_full_i = ($urandom_range(0, 5) == 0);
            trigger(m);
            if (m == 4'b0000) check("zero_mask_ignored", 64'(busy_o), 64'd0);
            wait_idle();
            bus.fifo_full_i = 1'b0;
            check("overrun_state", 64'(overrun_o), 64'(model_ovr));
            if ($urandom_range(0, 3) == 0) clear_overrun();
            repeat ($urandom_range(0, 7)) @(negedge PCLK);
        end

        // Reset in WAIT: outputs cleared, the late done must not produce a push.
        bus.fifo_full_i = 1'b1;
        trigger(4'b0001);
        wait_idle();
        bus.fifo_full_i = 1'b0;
        suppress  = 1'b1;
        delay_sel = 10;
        trigger(4'b0001);
        n = 0;
        while (exp_start_q.size() != 0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("rst_test_start_seen", 64'(n < 100), 64'd1);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        sb_q.delete();
        model_ovr = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_start", 64'(bus.adc_start_o), 64'd0);
        check("midrst_wr_en", 64'(bus.fifo_wr_en_o), 64'd0);
        check("midrst_wdata", 64'(bus.fifo_wdata_o), 64'd0);
        check("midrst_overrun", 64'(overrun_o), 64'd0);
        check("midrst_adc_ch", 64'(bus.adc_ch_o), 64'd0);
        base_cnt = push_cnt;
        repeat (20) @(negedge PCLK);
        check("midrst_no_push", 64'(push_cnt - base_cnt), 64'd0);
        suppress  = 1'b0;
        delay_sel = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
